// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: parametrised Moore sequence detector.
// A serial bit x, qualified by x_valid, is compared against PATTERN. The first
// bit received is PATTERN[PATTERN_W-1]. The state is the number of pattern bits
// currently matched. y is high while the accept state S[PATTERN_W] is held.
// OVERLAP=1 keeps the matched suffix after an accept. OVERLAP=0 restarts the
// history after an accept.
// Optional feature macro: SEQ_MATCH_CNT_EN adds a saturating match_count output.
module seq_detect_fsm #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter bit                   OVERLAP   = 1'b1,
    parameter int                   CNT_W     = 8,
    parameter int                   SW        = $clog2(PATTERN_W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          x,
    input  logic          x_valid,
    output logic          y,
    output logic [SW-1:0] currentState,
    output logic [SW-1:0] nextState
`ifdef SEQ_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] match_count
`endif
);

    typedef enum logic [SW-1:0] {
        S_IDLE   = '0,
        S_ACCEPT = SW'(PATTERN_W)
    } state_t;

    // One SW-bit entry for each (state, input bit) pair. States run from 0 to PATTERN_W.
    localparam int TBL_W = (PATTERN_W + 1) * 2 * SW;

    // This function gives the successor of state k on input bit b. It returns the
    // longest prefix of the pattern that is also a suffix of (prefix_k, b). A match
    // of the next bit is the case j = k+1.
    function automatic logic [SW-1:0] next_for(input int k, input logic b);
        int   best;
        int   m;
        logic ok;
        logic sb;
        logic pb;
        best = 0;
        if (k == PATTERN_W && !OVERLAP) begin
            best = (b == PATTERN[PATTERN_W-1]) ? 1 : 0;
        end else begin
            for (int j = 1; j <= PATTERN_W; j++) begin
                if (j <= k + 1) begin
                    ok = 1'b1;
                    for (int i = 0; i < j; i++) begin
                        // m is a position in the sequence (prefix_k, b). Position k is the new bit.
                        m = k + 1 - j + i;
                        if (m == k) begin
                            sb = b;
                        end else begin
                            sb = PATTERN[PATTERN_W-1-m];
                        end
                        pb = PATTERN[PATTERN_W-1-i];
                        if (sb != pb) begin
                            ok = 1'b0;
                        end
                    end
                    if (ok) begin
                        best = j;
                    end
                end
            end
        end
        return SW'(best);
    endfunction

    function automatic logic [TBL_W-1:0] build_table();
        logic [TBL_W-1:0] t;
        t = '0;
        for (int k = 0; k <= PATTERN_W; k++) begin
            for (int b = 0; b < 2; b++) begin
                t[(k*2+b)*SW +: SW] = next_for(k, b[0]);
            end
        end
        return t;
    endfunction

    // The transition table is a constant. No search logic exists in hardware.
    localparam logic [TBL_W-1:0] TRANS = build_table();

    state_t state_q;
    int     tbl_idx;

    assign currentState = state_q;

    // Next-state lookup. With x_valid low the state holds. An unreachable encoding returns to S0.
    always_comb begin
        nextState = state_q;
        tbl_idx   = 0;
        if (x_valid) begin
            if (state_q <= S_ACCEPT) begin
                tbl_idx   = int'({state_q, x}) * SW;
                nextState = TRANS[tbl_idx +: SW];
            end else begin
                nextState = '0;
            end
        end
    end

    // State register and registered Moore output. Reset overrides x_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            y       <= 1'b0;
        end else if (x_valid) begin
            state_q <= state_t'(nextState);
            y       <= (nextState == S_ACCEPT);
        end
    end

`ifdef SEQ_MATCH_CNT_EN
    // Count the valid bits that enter the accept state. The count saturates at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_count <= '0;
        end else if (x_valid && (nextState == S_ACCEPT) && (match_count != '1)) begin
            match_count <= match_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm with PATTERN=4'b1011.
// Two instances, one overlapping and one non-overlapping, receive the same stimulus.
// Their state, next state, y and (with SEQ_MATCH_CNT_EN) match_count are checked.
// The reference is the longest pattern prefix that is a suffix of the recent bit history.
module tb_seq_detect_fsm;

    localparam int          PW  = 4;
    localparam logic [3:0]  PAT = 4'b1011;
    localparam int          SW  = $clog2(PW + 1);
    localparam int          CW  = 2;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          x;
    logic          x_valid;
    logic          y_o, y_n;
    logic [SW-1:0] cs_o, ns_o, cs_n, ns_n;
`ifdef SEQ_MATCH_CNT_EN
    logic [CW-1:0] mc_o, mc_n;
`endif

    always #5 clk = ~clk;

    seq_detect_fsm #(.PATTERN_W(PW), .PATTERN(PAT), .OVERLAP(1'b1), .CNT_W(CW)) u_ovl (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .x_valid      (x_valid),
        .y            (y_o),
        .currentState (cs_o),
        .nextState    (ns_o)
`ifdef SEQ_MATCH_CNT_EN
        ,
        .match_count  (mc_o)
`endif
    );

    seq_detect_fsm #(.PATTERN_W(PW), .PATTERN(PAT), .OVERLAP(1'b0), .CNT_W(CW)) u_nov (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .x_valid      (x_valid),
        .y            (y_n),
        .currentState (cs_n),
        .nextState    (ns_n)
`ifdef SEQ_MATCH_CNT_EN
        ,
        .match_count  (mc_n)
`endif
    );

    typedef bit bq_t[$];

    typedef struct {
        bit chk_nxt;
        int nxt_o;
        int nxt_n;
        int st_o;
        int st_n;
        int cnt_o;
        int cnt_n;
        bit y_o;
        bit y_n;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bq_t  hist_o;
    bq_t  hist_n;
    int   cnt_o_m = 0;
    int   cnt_n_m = 0;
    bit   mdl_init = 0;

    // Length of the longest pattern prefix that ends the history.
    function automatic int match_len(input bq_t h);
        int         best;
        bit         ok;
        logic [3:0] p;
        p    = PAT;
        best = 0;
        for (int j = 1; j <= PW; j++) begin
            if (j <= h.size()) begin
                ok = 1;
                for (int i = 0; i < j; i++) begin
                    if (h[h.size()-j+i] != p[PW-1-i]) ok = 0;
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    // History after one valid bit. Non-overlapping mode forgets everything after a full match.
    function automatic bq_t advance(input bq_t h, input bit ov, input bit xb);
        bq_t t;
        if (!ov && match_len(h) == PW) begin
            t.delete();
            t.push_back(xb);
        end else begin
            t = h;
            t.push_back(xb);
        end
        while (t.size() > PW) void'(t.pop_front());
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the expected response.
    task automatic drive(input bit r, input bit v, input bit xb);
        exp_t e;
        bq_t  a_o;
        bq_t  a_n;
        @(negedge clk);
        reset   = r;
        x_valid = v;
        x       = xb;
        e.chk_nxt = mdl_init;
        a_o = advance(hist_o, 1'b1, xb);
        a_n = advance(hist_n, 1'b0, xb);
        e.nxt_o = v ? match_len(a_o) : match_len(hist_o);
        e.nxt_n = v ? match_len(a_n) : match_len(hist_n);
        if (r) begin
            hist_o.delete();
            hist_n.delete();
            cnt_o_m  = 0;
            cnt_n_m  = 0;
            mdl_init = 1;
        end else if (v) begin
            hist_o = a_o;
            hist_n = a_n;
            if (e.nxt_o == PW && cnt_o_m < CMAX) cnt_o_m++;
            if (e.nxt_n == PW && cnt_n_m < CMAX) cnt_n_m++;
        end
        e.st_o  = match_len(hist_o);
        e.st_n  = match_len(hist_n);
        e.y_o   = (e.st_o == PW);
        e.y_n   = (e.st_n == PW);
        e.cnt_o = cnt_o_m;
        e.cnt_n = cnt_n_m;
        sbq.push_back(e);
    endtask

    task automatic drive_bits(input logic [15:0] bits, input int n);
        logic [15:0] b;
        b = bits;
        for (int i = n - 1; i >= 0; i--) drive(0, 1, b[i]);
    endtask

    // Monitor: check nextState before the edge and the registered outputs after it.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sbq.size() > 0) begin
                if (sbq[0].chk_nxt) begin
                    chk("nextState_ovl", int'(ns_o), sbq[0].nxt_o);
                    chk("nextState_nov", int'(ns_n), sbq[0].nxt_n);
                end
                @(posedge clk);
                #1;
                e = sbq.pop_front();
                chk("state_ovl", int'(cs_o), e.st_o);
                chk("state_nov", int'(cs_n), e.st_n);
                chk("y_ovl", int'(y_o), int'(e.y_o));
                chk("y_nov", int'(y_n), int'(e.y_n));
`ifdef SEQ_MATCH_CNT_EN
                chk("count_ovl", int'(mc_o), e.cnt_o);
                chk("count_nov", int'(mc_n), e.cnt_n);
`endif
            end
        end
    end

    initial begin : stim
        int budget;
        reset   = 1'b1;
        x_valid = 1'b0;
        x       = 1'b0;

        // Reset, then hold x_valid low for 5 cycles.
        drive(1, 0, 0);
        drive(1, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1'($urandom_range(0, 1)));

        // Stream 1,0,1,1,0,1,1.
        drive_bits(16'b1011011, 7);

        // Stream 1,0,1, a 3-cycle gap, then the final 1.
        drive(1, 0, 0);
        drive_bits(16'b101, 3);
        for (int i = 0; i < 3; i++) drive(0, 0, 1'($urandom_range(0, 1)));
        drive(0, 1, 1);

        // Reset mid-sequence while a valid final bit is presented.
        drive(1, 0, 0);
        drive_bits(16'b101, 3);
        drive(1, 1, 1);
        drive(0, 0, 0);

        // Five full matches. The 2-bit counter saturates.
        drive(1, 0, 0);
        for (int i = 0; i < 5; i++) drive_bits(16'b1011, 4);
        drive(0, 0, 0);

        // Random traffic with sparse resets.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)));
        end
        drive(0, 0, 0);

        budget = 0;
        while (sbq.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #5;
        if (sbq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
